uart_cmd_responder: RTL and testbench

Host-facing command endpoint of the scope's serial link: consumes bytes from uart_rx, decodes fixed 5-byte command frames, and performs 8-bit register writes and reads on the internal register bus. Sends a 2-byte response frame back through uart_tx. Sits between the uart_rx/uart_tx pair and the oscilloscope control register file.

---
 rtl/uart_cmd_responder_pkg.sv | 25 ++
 rtl/uart_byte_timeout.sv | 38 +++
 rtl/uart_cmd_responder.sv | 154 +++++++++++++++
 tb/tb_uart_cmd_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_responder_pkg.sv
// Shared constants for the UART command responder: frame bytes, command and
// error codes, and the FSM state encodings.
package uart_cmd_responder_pkg;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] ACK     = 8'h5A;
    localparam logic [7:0] NAK     = 8'hEE;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] ERR_CHK = 8'h01;
    localparam logic [7:0] ERR_CMD = 8'h02;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_GET_CMD  = 4'd1;
    localparam logic [3:0] ST_GET_ADDR = 4'd2;
    localparam logic [3:0] ST_GET_DATA = 4'd3;
    localparam logic [3:0] ST_GET_CHK  = 4'd4;
    localparam logic [3:0] ST_EXEC     = 4'd5;
    localparam logic [3:0] ST_RD_WAIT  = 4'd6;
    localparam logic [3:0] ST_TX_HDR   = 4'd7;
    localparam logic [3:0] ST_WAIT_HDR = 4'd8;
    localparam logic [3:0] ST_TX_PLD   = 4'd9;
    localparam logic [3:0] ST_WAIT_PLD = 4'd10;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte timeout counter: cleared on demand, counts while enabled and
// flags expiry once the count reaches TIMEOUT_CLKS-1.
module uart_byte_timeout #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturate at the limit so a held enable never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = i_enable && !i_clear && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes 5-byte command frames from uart_rx, performs one register write or
// read, and returns a 2-byte ACK/NAK response through uart_tx.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_data_valid,
    input  logic [7:0] i_rx_byte,
    output logic [7:0] o_tx_data,
    output logic       o_tx_data_valid,
    input  logic       i_tx_done,
    output logic [7:0] o_reg_addr,
    output logic       o_reg_wr_en,
    output logic [7:0] o_reg_wr_data,
    output logic       o_reg_rd_en,
    input  logic [7:0] i_reg_rd_data,
    output logic       o_busy
);

    logic [3:0] state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] pld_q, pld_d;
    logic       in_frame;
    logic       tmo_clear;
    logic       tmo_expire;
    logic       chk_ok;

    assign in_frame  = (state_q == ST_GET_CMD) || (state_q == ST_GET_ADDR) ||
                       (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
    assign tmo_clear = i_rx_data_valid || (state_q == ST_IDLE);
    assign chk_ok    = (chk_q == (cmd_q ^ addr_q ^ data_q));

    uart_byte_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (tmo_clear),
        .i_enable(in_frame),
        .o_expire(tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        hdr_d       = hdr_q;
        pld_d       = pld_q;
        o_reg_wr_en = 1'b0;
        o_reg_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_data_valid && (i_rx_byte == SYNC)) state_d = ST_GET_CMD;
            end
            ST_GET_CMD: begin
                if (i_rx_data_valid) begin
                    cmd_d   = i_rx_byte;
                    state_d = ST_GET_ADDR;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_ADDR: begin
                if (i_rx_data_valid) begin
                    addr_d  = i_rx_byte;
                    state_d = ST_GET_DATA;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (i_rx_data_valid) begin
                    data_d  = i_rx_byte;
                    state_d = ST_GET_CHK;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_CHK: begin
                if (i_rx_data_valid) begin
                    chk_d   = i_rx_byte;
                    state_d = ST_EXEC;
                end else if (tmo_expire) begin
                    state_d = ST_IDLE;
                end
            end
            // Checksum is judged before the command code.
            ST_EXEC: begin
                state_d = ST_TX_HDR;
                if (!chk_ok) begin
                    hdr_d = NAK;
                    pld_d = ERR_CHK;
                end else if (cmd_q == CMD_WR) begin
                    o_reg_wr_en = 1'b1;
                    hdr_d       = ACK;
                    pld_d       = data_q;
                end else if (cmd_q == CMD_RD) begin
                    o_reg_rd_en = 1'b1;
                    hdr_d       = ACK;
                    state_d     = ST_RD_WAIT;
                end else begin
                    hdr_d = NAK;
                    pld_d = ERR_CMD;
                end
            end
            ST_RD_WAIT: begin
                pld_d   = i_reg_rd_data;
                state_d = ST_TX_HDR;
            end
            ST_TX_HDR:   state_d = ST_WAIT_HDR;
            ST_WAIT_HDR: if (i_tx_done) state_d = ST_TX_PLD;
            ST_TX_PLD:   state_d = ST_WAIT_PLD;
            ST_WAIT_PLD: if (i_tx_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            chk_q   <= '0;
            hdr_q   <= '0;
            pld_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            hdr_q   <= hdr_d;
            pld_q   <= pld_d;
        end
    end

    assign o_busy          = (state_q != ST_IDLE);
    assign o_tx_data_valid = (state_q == ST_TX_HDR) || (state_q == ST_TX_PLD);
    assign o_tx_data       = ((state_q == ST_TX_HDR) || (state_q == ST_WAIT_HDR)) ? hdr_q :
                             ((state_q == ST_TX_PLD) || (state_q == ST_WAIT_PLD)) ? pld_q : 8'h00;
    assign o_reg_addr      = addr_q;
    assign o_reg_wr_data   = data_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed, table-driven bench for uart_cmd_responder with a small host and
// uart_tx / register-file responder model.
module tb_uart_cmd_responder;

    localparam int TIMEOUT = 16;
    localparam int TX_DELAY = 5;
    localparam int MAX_CYC = 200;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_rx_data_valid;
    logic [7:0] i_rx_byte;
    logic [7:0] o_tx_data;
    logic       o_tx_data_valid;
    logic       i_tx_done;
    logic [7:0] o_reg_addr;
    logic       o_reg_wr_en;
    logic [7:0] o_reg_wr_data;
    logic       o_reg_rd_en;
    logic [7:0] i_reg_rd_data;
    logic       o_busy;

    int assertions = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] chk;
        logic [7:0] rdData;
        bit         expWr;
        bit         expRd;
        logic [7:0] expHdr;
        logic [7:0] expPld;
    } vec_t;

    vec_t vecs[8];

    uart_cmd_responder #(.TIMEOUT_CLKS(TIMEOUT)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_rx_data_valid(i_rx_data_valid),
        .i_rx_byte      (i_rx_byte),
        .o_tx_data      (o_tx_data),
        .o_tx_data_valid(o_tx_data_valid),
        .i_tx_done      (i_tx_done),
        .o_reg_addr     (o_reg_addr),
        .o_reg_wr_en    (o_reg_wr_en),
        .o_reg_wr_data  (o_reg_wr_data),
        .o_reg_rd_en    (o_reg_rd_en),
        .i_reg_rd_data  (i_reg_rd_data),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        i_rx_byte = b;
        i_rx_data_valid = 1'b1;
        tick();
        i_rx_data_valid = 1'b0;
    endtask

    // Sends one frame, then plays uart_tx and the register file until the
    // response completes, recording strobes, tx bytes and latencies.
    task automatic applyStimulus(input vec_t v, input int idx);
        int wrCnt = 0, rdCnt = 0, txn = 0, firstTx = -1, wrCyc = -1;
        int cd = 0, holdErr = 0, protoErr = 0;
        bit pending = 0, rdPend = 0, finished = 0;
        logic [7:0] wrAddr = 0, wrData = 0, rdAddr = 0, held = 0;
        logic [7:0] txBytes[2];
        txBytes[0] = 8'h00;
        txBytes[1] = 8'h00;
        sendByte(8'hA5);
        sendByte(v.cmd);
        sendByte(v.addr);
        sendByte(v.data);
        sendByte(v.chk);
        for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
            i_tx_done = 1'b0;
            i_reg_rd_data = 8'h00;
            if (rdPend) begin
                i_reg_rd_data = v.rdData;
                rdPend = 0;
            end
            if (o_reg_rd_en) begin
                rdCnt++;
                rdAddr = o_reg_addr;
                rdPend = 1;
            end
            if (o_reg_wr_en) begin
                wrCnt++;
                wrCyc = cyc;
                wrAddr = o_reg_addr;
                wrData = o_reg_wr_data;
            end
            if (o_tx_data_valid) begin
                if (pending) protoErr++;
                if (txn < 2) txBytes[txn] = o_tx_data;
                if (txn == 0) firstTx = cyc;
                txn++;
                pending = 1;
                cd = TX_DELAY;
                held = o_tx_data;
            end else if (pending) begin
                if (o_tx_data !== held) holdErr++;
                cd--;
                if (cd == 0) begin
                    i_tx_done = 1'b1;
                    pending = 0;
                end
            end
            if (!pending && txn >= 2 && !o_busy) begin
                finished = 1;
                break;
            end
            tick();
        end
        i_tx_done = 1'b0;
        i_reg_rd_data = 8'h00;
        checkOutput($sformatf("v%0d_finished", idx), 32'(finished), 32'd1);
        checkOutput($sformatf("v%0d_wr_count", idx), wrCnt, v.expWr ? 1 : 0);
        checkOutput($sformatf("v%0d_rd_count", idx), rdCnt, v.expRd ? 1 : 0);
        if (v.expWr) begin
            checkOutput($sformatf("v%0d_wr_addr", idx), wrAddr, v.addr);
            checkOutput($sformatf("v%0d_wr_data", idx), wrData, v.data);
            checkOutput($sformatf("v%0d_wr_latency", idx), wrCyc, 0);
        end
        if (v.expRd) checkOutput($sformatf("v%0d_rd_addr", idx), rdAddr, v.addr);
        checkOutput($sformatf("v%0d_tx_count", idx), txn, 2);
        checkOutput($sformatf("v%0d_tx_hdr", idx), txBytes[0], v.expHdr);
        checkOutput($sformatf("v%0d_tx_pld", idx), txBytes[1], v.expPld);
        checkOutput($sformatf("v%0d_tx_latency", idx), firstTx, v.expRd ? 2 : 1);
        checkOutput($sformatf("v%0d_tx_hold", idx), holdErr, 0);
        checkOutput($sformatf("v%0d_tx_overlap", idx), protoErr, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(o_busy), 0);
        checkOutput({tag, "_tx_valid"}, 32'(o_tx_data_valid), 0);
        checkOutput({tag, "_tx_data"}, o_tx_data, 0);
        checkOutput({tag, "_wr_en"}, 32'(o_reg_wr_en), 0);
        checkOutput({tag, "_rd_en"}, 32'(o_reg_rd_en), 0);
        checkOutput({tag, "_addr"}, o_reg_addr, 0);
        checkOutput({tag, "_wr_data"}, o_reg_wr_data, 0);
    endtask

    initial begin
        int activity;
        int seen;
        //            cmd    addr   data   chk    rdData wr rd hdr    pld
        vecs[0] = '{8'h01, 8'h10, 8'h3C, 8'h2D, 8'h00, 1, 0, 8'h5A, 8'h3C};
        vecs[1] = '{8'h02, 8'h22, 8'h00, 8'h20, 8'h99, 0, 1, 8'h5A, 8'h99};
        vecs[2] = '{8'h01, 8'h10, 8'h3C, 8'h00, 8'h00, 0, 0, 8'hEE, 8'h01};
        vecs[3] = '{8'h07, 8'h10, 8'h3C, 8'h2B, 8'h00, 0, 0, 8'hEE, 8'h02};
        vecs[4] = '{8'h01, 8'hA5, 8'h11, 8'hB5, 8'h00, 1, 0, 8'h5A, 8'h11};
        vecs[5] = '{8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 0, 0, 8'hEE, 8'h02};
        vecs[6] = '{8'h02, 8'hFF, 8'h55, 8'hA8, 8'h6B, 0, 1, 8'h5A, 8'h6B};
        vecs[7] = '{8'h07, 8'h10, 8'h3C, 8'h00, 8'h00, 0, 0, 8'hEE, 8'h01};

        i_rst = 1'b1;
        i_rx_data_valid = 1'b0;
        i_rx_byte = 8'h00;
        i_tx_done = 1'b0;
        i_reg_rd_data = 8'h00;
        repeat (3) @(posedge i_clk);
        #1;
        checkAllZero("reset");
        i_rst = 1'b0;
        tick();

        // Non-sync bytes and a stray tx_done in IDLE are ignored.
        sendByte(8'h3C);
        sendByte(8'h5A);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        checkOutput("idle_drop_busy", 32'(o_busy), 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
            tick();
        end

        // Partial frame times out exactly TIMEOUT clocks after its last byte.
        activity = 0;
        sendByte(8'hA5);
        sendByte(8'h01);
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            if (o_reg_wr_en || o_reg_rd_en || o_tx_data_valid) activity++;
            tick();
        end
        checkOutput("timeout_busy_before", 32'(o_busy), 1);
        tick();
        checkOutput("timeout_busy_after", 32'(o_busy), 0);
        for (int k = 0; k < 4; k++) begin
            if (o_reg_wr_en || o_reg_rd_en || o_tx_data_valid) activity++;
            tick();
        end
        checkOutput("timeout_no_activity", activity, 0);
        applyStimulus(vecs[0], 100);
        tick();

        // Reset asserted mid-cycle while waiting for the header's tx_done.
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h10);
        sendByte(8'h3C);
        sendByte(8'h2D);
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            if (o_tx_data_valid) seen = 1;
            tick();
        end
        checkOutput("rst_hdr_seen", seen, 1);
        #2;
        i_rst = 1'b1;
        #1;
        checkAllZero("midrst");
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        activity = 0;
        for (int k = 0; k < 20; k++) begin
            i_tx_done = (k == 3);
            if (o_tx_data_valid || o_busy) activity++;
            tick();
        end
        i_tx_done = 1'b0;
        checkOutput("post_rst_quiet", activity, 0);
        applyStimulus(vecs[1], 101);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
